control_fsm: RTL
================

CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have parameter DW, default 8, meaning datapath, memory-address and register width (DW >= 8).
REQ-002 SHALL have parameter RIW, default 4, meaning register-index width (RIW >= 4).
REQ-003 SHALL have parameter CW, default 16, meaning retired-instruction counter width.
REQ-004 SHALL have ports, in this order:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- instruction  in  9  fetched word.
- inst_valid  in  1  instruction is valid.
- inst_ready  out  1  FSM accepts an instruction.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  DW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_ack  in  1  memory completion.
- mem_rdata  in  DW  memory read data.
- reg_we  out  1  register write strobe.
- reg_i_a, reg_i_b, reg_i_write  out  RIW  register indices.
- reg_write_in  out  DW  register write data.
- reg_a, reg_b  in  DW  register read values.
- alu_op  out  4  ALU operation.
- alu_zero  in  1  ALU zero flag.
- alu_out  in  DW  ALU result.
- lut_type  out  3  LUT select.
- lut_out  in  DW  LUT result.
- immediate  out  5  immediate value.
- pc_advance  out  1  one-cycle retire pulse.
- take_branch  out  1  valid with pc_advance.
- halted  out  1  FSM is in HALT.
- resume  in  1  leave HALT.
- retired  out  CW  retired-instruction count.

Function
REQ-005 SHALL decode opcode = ir[8:6] and funct = ir[1:0] from the internal instruction register ir, using these opcodes: 000 LW, 001 SW, 010 SET, 011 ADDgrp, 100 SLLgrp, 101 NEGgrp, 110 Bgrp, 111 MOV.
REQ-006 SHALL decode funct per group as follows:
- ADDgrp: ADD, ADDC, SUB, LWR.
- SLLgrp: SLL, SRA, SRL, NOP.
- NEGgrp: NEG, AND, OR, HALT.
- Bgrp: BEQ, BNE, BLTS, BLT.
REQ-007 SHALL use alu_op encodings ADD=0, ADDC=1, SUB=2, SLL=3, SRA=4, SRL=5, NEG=6, AND=7, OR=8, LTS=9, LT=10.
REQ-008 SHALL use lut_type encodings LW=0, SW=1, BEQ=2, BNE=3, BLTS=4, BLT=5.
REQ-009 SHALL implement states FETCH, EXEC, MEM and HALT, and SHALL make every output 0 whenever it is not explicitly driven.
REQ-010 FETCH SHALL assert inst_ready, and on inst_valid SHALL latch instruction into ir and move to EXEC.
REQ-011 EXEC SHALL last exactly one cycle and drive decode outputs combinationally from ir:
- immediate = ir[4:0] for LW/SW/SET.
- immediate = {0, ir[5:2]} for Bgrp.
REQ-012 EXEC SHALL handle SET, MOV, ADDgrp (except LWR), SLLgrp and NEGgrp (except HALT) as follows:
- SET: reg_we=1, reg_i_write=ir[5], reg_write_in = zero-extended immediate.
- MOV: reg_i_a=ir[5:2], reg_i_write=ir[1], reg_write_in=reg_a.
- R ops: reg_i_a=0, reg_i_b=1, reg_i_write=ir[5:2], reg_write_in=alu_out.
- All of these: pulse pc_advance, then return to FETCH.
- NOP: pc_advance only.
REQ-013 EXEC for Bgrp SHALL set reg_i_a=0, reg_i_b=1, alu_op SUB/SUB/LTS/LT and take_branch = alu_zero / ~alu_zero / alu_out[0] / alu_out[0], pulse pc_advance, and go to FETCH.
REQ-014 EXEC for LW, SW and LWR SHALL go to MEM.
REQ-015 MEM SHALL assert mem_req, holding it and all address and data outputs stable until mem_ack.
REQ-016 MEM addressing SHALL be as follows:
- LW: mem_addr=lut_out with lut_type=LW.
- SW: mem_addr=lut_out with lut_type=SW, mem_we=1, reg_i_a=ir[5], mem_wdata=reg_a.
- LWR: reg_i_a=0, mem_addr=reg_a.
REQ-017 On the mem_ack cycle, loads SHALL assert reg_we with reg_write_in=mem_rdata and reg_i_write = ir[5] for LW or ir[5:2] for LWR, pulse pc_advance, and go to FETCH; a mem_ack outside MEM SHALL be ignored.
REQ-018 HALT SHALL be entered from EXEC on NEGgrp funct 11, which pulses pc_advance; HALT SHALL assert halted, keep inst_ready=0, and on resume move to FETCH.
REQ-019 retired SHALL increment by 1 on every pc_advance and wrap from 2^CW-1 to 0.
REQ-020 Throughput SHALL be 2 cycles per non-memory instruction, and 2 + ack-wait + 1 cycles per memory instruction.

Reset
REQ-021 Reset SHALL force FETCH immediately and asynchronously, clear ir and retired, deassert mem_req, reg_we and pc_advance, and set halted=0.
REQ-022 Reset asserted in MEM SHALL drop mem_req in the same cycle, and a later mem_ack SHALL cause no register write.

Verification
REQ-023 The bench SHALL cover SET: instruction 010_1_10101 -> next cycle reg_we=1, reg_i_write=1, reg_write_in=0x15, pc_advance=1, retired=1.
REQ-024 The bench SHALL cover LW with wait: 000_0_00011, lut_out=0x40, mem_ack after 3 cycles -> mem_req high for 3 cycles, mem_addr=0x40, reg write on the ack cycle.
REQ-025 The bench SHALL cover BNE: reg_a=5, reg_b=5, funct 01 -> alu_op=2, take_branch=0; with reg_b=6 -> take_branch=1.
REQ-026 The bench SHALL cover HALT then resume: 101_xxxx_11 -> halted=1 and inst_ready=0 for 10 cycles; resume=1 -> FETCH, halted=0.
REQ-027 The bench SHALL cover reset mid-MEM: reset during the SW wait -> mem_req=0 asynchronously, retired=0, and a subsequent mem_ack is ignored.
REQ-028 The bench SHALL cover counter wrap: CW=2, 5 retired instructions -> retired=1.

Source files
------------

// File: rtl/control_fsm.sv
// Multi-cycle instruction sequencer: fetch, single-cycle execute, and a memory phase
// that waits on mem_ack. It drives the regfile, ALU, LUT and memory ports.
module control_fsm #(
    parameter int DW  = 8,
    parameter int RIW = 4,
    parameter int CW  = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [8:0]     instruction,
    input  logic           inst_valid,
    output logic           inst_ready,
    output logic           mem_req,
    output logic           mem_we,
    output logic [DW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wdata,
    input  logic           mem_ack,
    input  logic [DW-1:0]  mem_rdata,
    output logic           reg_we,
    output logic [RIW-1:0] reg_i_a,
    output logic [RIW-1:0] reg_i_b,
    output logic [RIW-1:0] reg_i_write,
    output logic [DW-1:0]  reg_write_in,
    input  logic [DW-1:0]  reg_a,
    input  logic [DW-1:0]  reg_b,
    output logic [3:0]     alu_op,
    input  logic           alu_zero,
    input  logic [DW-1:0]  alu_out,
    output logic [2:0]     lut_type,
    input  logic [DW-1:0]  lut_out,
    output logic [4:0]     immediate,
    output logic           pc_advance,
    output logic           take_branch,
    output logic           halted,
    input  logic           resume,
    output logic [CW-1:0]  retired
);

    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_SW  = 3'b001;
    localparam logic [2:0] OP_SET = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_NEG = 3'b101;
    localparam logic [2:0] OP_B   = 3'b110;
    localparam logic [2:0] OP_MOV = 3'b111;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_SLL = 4'd3;
    localparam logic [3:0] ALU_NEG = 4'd6;
    localparam logic [3:0] ALU_LTS = 4'd9;
    localparam logic [3:0] ALU_LT  = 4'd10;

    localparam logic [2:0] LUT_LW  = 3'd0;
    localparam logic [2:0] LUT_SW  = 3'd1;
    localparam logic [2:0] LUT_BEQ = 3'd2;

    state_t     state, state_nxt;
    logic [8:0] ir;
    logic [2:0] opcode;
    logic [1:0] funct;
    logic       r_op;

    assign opcode = ir[8:6];
    assign funct  = ir[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            ir      <= '0;
            retired <= '0;
        end else begin
            state <= state_nxt;
            if (state == FETCH && inst_valid)
                ir <= instruction;
            if (pc_advance)
                retired <= retired + CW'(1);
        end
    end

    always_comb begin
        state_nxt    = state;
        r_op         = 1'b0;
        inst_ready   = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        reg_we       = 1'b0;
        reg_i_a      = '0;
        reg_i_b      = '0;
        reg_i_write  = '0;
        reg_write_in = '0;
        alu_op       = '0;
        lut_type     = '0;
        immediate    = '0;
        pc_advance   = 1'b0;
        take_branch  = 1'b0;
        halted       = 1'b0;

        case (state)
            FETCH: begin
                inst_ready = 1'b1;
                if (inst_valid)
                    state_nxt = EXEC;
            end
            EXEC: begin
                state_nxt = FETCH;
                case (opcode)
                    OP_LW, OP_SW: begin
                        immediate = ir[4:0];
                        lut_type  = (opcode == OP_SW) ? LUT_SW : LUT_LW;
                        state_nxt = MEM;
                    end
                    OP_SET: begin
                        immediate    = ir[4:0];
                        reg_we       = 1'b1;
                        reg_i_write  = RIW'(ir[5]);
                        reg_write_in = DW'(ir[4:0]);
                        pc_advance   = 1'b1;
                    end
                    OP_ADD: begin
                        if (funct == 2'b11) state_nxt = MEM;
                        else begin
                            r_op   = 1'b1;
                            alu_op = ALU_ADD + 4'(funct);
                        end
                    end
                    OP_SLL: begin
                        if (funct == 2'b11) pc_advance = 1'b1;
                        else begin
                            r_op   = 1'b1;
                            alu_op = ALU_SLL + 4'(funct);
                        end
                    end
                    OP_NEG: begin
                        if (funct == 2'b11) begin
                            pc_advance = 1'b1;
                            state_nxt  = HALT;
                        end else begin
                            r_op   = 1'b1;
                            alu_op = ALU_NEG + 4'(funct);
                        end
                    end
                    OP_B: begin
                        reg_i_a    = '0;
                        reg_i_b    = RIW'(1);
                        immediate  = {1'b0, ir[5:2]};
                        lut_type   = LUT_BEQ + 3'(funct);
                        pc_advance = 1'b1;
                        case (funct)
                            2'b00: begin alu_op = ALU_SUB; take_branch = alu_zero;   end
                            2'b01: begin alu_op = ALU_SUB; take_branch = ~alu_zero;  end
                            2'b10: begin alu_op = ALU_LTS; take_branch = alu_out[0]; end
                            default: begin alu_op = ALU_LT; take_branch = alu_out[0]; end
                        endcase
                    end
                    default: begin // MOV
                        reg_we       = 1'b1;
                        reg_i_a      = RIW'(ir[5:2]);
                        reg_i_write  = RIW'(ir[1]);
                        reg_write_in = reg_a;
                        pc_advance   = 1'b1;
                    end
                endcase
                // Register-register ALU ops share operand routing and writeback.
                if (r_op) begin
                    reg_we       = 1'b1;
                    reg_i_a      = '0;
                    reg_i_b      = RIW'(1);
                    reg_i_write  = RIW'(ir[5:2]);
                    reg_write_in = alu_out;
                    pc_advance   = 1'b1;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                case (opcode)
                    OP_LW: begin
                        immediate = ir[4:0];
                        lut_type  = LUT_LW;
                        mem_addr  = lut_out;
                    end
                    OP_SW: begin
                        immediate = ir[4:0];
                        lut_type  = LUT_SW;
                        mem_addr  = lut_out;
                        mem_we    = 1'b1;
                        reg_i_a   = RIW'(ir[5]);
                        mem_wdata = reg_a;
                    end
                    default: begin // LWR
                        reg_i_a  = '0;
                        mem_addr = reg_a;
                    end
                endcase
                if (mem_ack) begin
                    pc_advance = 1'b1;
                    state_nxt  = FETCH;
                    if (opcode != OP_SW) begin
                        reg_we       = 1'b1;
                        reg_write_in = mem_rdata;
                        reg_i_write  = (opcode == OP_LW) ? RIW'(ir[5]) : RIW'(ir[5:2]);
                    end
                end
            end
            default: begin // HALT
                halted = 1'b1;
                if (resume)
                    state_nxt = FETCH;
            end
        endcase
    end

endmodule
